// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller for a double-buffered frame/depth
// buffer pair and the rasterizer, running in the render clock domain.
//
// Each frame: wait for vsync, pulse clear, let the clear settle and wait for
// buffers_ready, pulse render_start, wait for render_done, then swap the
// front/back buffers on the next vsync. Missed vsyncs (overruns) and
// rasterizer hangs (timeouts) are counted and flagged.
//
// Ports:
//   clk, rstn          render clock, async active-low reset
//   enable             run frames while high
//   vsync              async level from the pixel domain
//   buffers_ready      framebuffer & depth buffer ready
//   render_done        one-cycle completion pulse from the rasterizer
//   flags_clr          clears the sticky overrun/timeout flags
//   clear              one-cycle clear pulse to both buffers
//   render_start       one-cycle start pulse to the rasterizer
//   front_buffer       displayed buffer index (back = ~front_buffer)
//   busy               state != IDLE
//   frame_count        completed swaps (wraps)
//   drop_count         vsyncs seen while rendering (saturates)
//   overrun, timeout   sticky event flags
module frame_sequencer #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int RENDER_TIMEOUT  = 2000000,
  parameter int CLEAR_SETTLE    = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       vsync,
  input  logic                       buffers_ready,
  input  logic                       render_done,
  input  logic                       flags_clr,
  output logic                       clear,
  output logic                       render_start,
  output logic                       front_buffer,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [FRAME_CNT_WIDTH-1:0] drop_count,
  output logic                       overrun,
  output logic                       timeout
);

  localparam int TW          = $clog2(RENDER_TIMEOUT + 1);
  localparam int SW          = $clog2(CLEAR_SETTLE + 2);
  localparam int SETTLE_LAST = (CLEAR_SETTLE > 0) ? CLEAR_SETTLE - 1 : 0;
  // The timer starts at 0 in the first WAIT_RENDER cycle; firing when it
  // reaches RENDER_TIMEOUT-2 (i.e. about to become RENDER_TIMEOUT-1) makes
  // the timeout flag visible exactly RENDER_TIMEOUT cycles after the
  // render_start pulse.
  localparam int TMO_LAST    = (RENDER_TIMEOUT >= 2) ? RENDER_TIMEOUT - 2 : 0;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_CLEAR, START, WAIT_RENDER, WAIT_VSYNC
  } state_t;

  state_t state, next_state;

  // vsync synchronizer and registered rising-edge detect
  logic vs_s1, vs_s2, vs_s2_d, vs_rise;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_s2_d <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      vs_s1   <= vsync;
      vs_s2   <= vs_s1;
      vs_s2_d <= vs_s2;
      vs_rise <= vs_s2 & ~vs_s2_d;
    end
  end

  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          aborted;
  logic          settle_done, tmo_hit;
  logic          swap, drop_evt, tmo_evt;

  assign settle_done = (settle_cnt >= SW'(SETTLE_LAST));
  assign tmo_hit     = (tmo_cnt == TW'(TMO_LAST));

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // next-state and frame events
  always_comb begin
    next_state = state;
    swap       = 1'b0;
    drop_evt   = 1'b0;
    tmo_evt    = 1'b0;
    case (state)
      IDLE:       if (enable && vs_rise) next_state = CLEAR;
      CLEAR:      next_state = WAIT_CLEAR;
      WAIT_CLEAR: if (settle_done && buffers_ready) next_state = START;
      START:      next_state = WAIT_RENDER;
      WAIT_RENDER: begin
        if (render_done && vs_rise) begin
          // completion consumes the edge: swap right away
          swap       = 1'b1;
          next_state = enable ? CLEAR : IDLE;
        end else if (render_done) begin
          next_state = WAIT_VSYNC;
        end else begin
          drop_evt = vs_rise;
          if (tmo_hit) begin
            tmo_evt    = 1'b1;
            next_state = WAIT_VSYNC;
          end
        end
      end
      WAIT_VSYNC: begin
        if (vs_rise) begin
          swap       = ~aborted;
          next_state = enable ? CLEAR : IDLE;
        end
      end
      default:    next_state = IDLE;
    endcase
  end

  // output decode from the upcoming state, registered below
  logic clear_d, start_d, busy_d;

  always_comb begin
    clear_d = (next_state == CLEAR);
    start_d = (next_state == START);
    busy_d  = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clear        <= 1'b0;
      render_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      clear        <= clear_d;
      render_start <= start_d;
      busy         <= busy_d;
    end
  end

  // timers, buffer index, counters and flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      aborted      <= 1'b0;
      front_buffer <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (state == CLEAR)                          settle_cnt <= '0;
      else if (state == WAIT_CLEAR && !settle_done) settle_cnt <= settle_cnt + SW'(1);

      if (state == START)            tmo_cnt <= '0;
      else if (state == WAIT_RENDER) tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_evt)                               aborted <= 1'b1;
      else if (state == WAIT_VSYNC && vs_rise)   aborted <= 1'b0;

      if (swap) begin
        front_buffer <= ~front_buffer;
        frame_count  <= frame_count + FRAME_CNT_WIDTH'(1);
      end

      if (drop_evt && drop_count != '1) drop_count <= drop_count + FRAME_CNT_WIDTH'(1);

      // a set event in the same cycle as flags_clr wins
      if (drop_evt)       overrun <= 1'b1;
      else if (flags_clr) overrun <= 1'b0;

      if (tmo_evt)        timeout <= 1'b1;
      else if (flags_clr) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer (RENDER_TIMEOUT shortened to 100).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable, vsync, buffers_ready, render_done, flags_clr;
  logic        clear, render_start, front_buffer, busy, overrun, timeout;
  logic [15:0] frame_count, drop_count;

  int errors = 0;
  int checks = 0;

  frame_sequencer #(
    .FRAME_CNT_WIDTH(16),
    .RENDER_TIMEOUT (100),
    .CLEAR_SETTLE   (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .vsync        (vsync),
    .buffers_ready(buffers_ready),
    .render_done  (render_done),
    .flags_clr    (flags_clr),
    .clear        (clear),
    .render_start (render_start),
    .front_buffer (front_buffer),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle vsync; its effect is visible after the 4th tick from the drive
  task automatic vsync_edge();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic done_pulse();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    rstn = 1'b0; enable = 1'b0; vsync = 1'b0; buffers_ready = 1'b0;
    render_done = 1'b0; flags_clr = 1'b0;
    #22;
    outs = {clear, render_start, front_buffer, busy, overrun, timeout, frame_count, drop_count};
    checks++; if (outs !== 38'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    enable = 1'b1; buffers_ready = 1'b1;
    vsync = 1'b1;                          // t0 = 0
    for (int k = 1; k <= 204; k++) begin
      tick();
      if (clear && render_start) begin errors++; $display("FAIL basic_overlap at %0d clear and render_start both 1", k); end
      case (k)
        3: begin
          checks++; if (clear !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_t3 clear=%b busy=%b want 0 0", clear, busy); end
        end
        4: begin
          checks++; if (clear !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_clear_t4 clear=%b busy=%b want 1 1", clear, busy); end
        end
        6: begin
          checks++; if (render_start !== 1'b0) begin errors++; $display("FAIL basic_settle render_start got %b want 0", render_start); end
        end
        7: begin
          checks++; if (render_start !== 1'b1) begin errors++; $display("FAIL basic_start_t7 render_start got %b want 1", render_start); end
        end
        8: begin
          checks++; if (render_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse render_start got %b want 0", render_start); end
        end
        203: begin
          checks++; if (front_buffer !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL basic_preswap front=%b count=%0d want 0 0", front_buffer, frame_count); end
        end
        204: begin
          checks++; if (front_buffer !== 1'b1 || frame_count !== 16'd1 || clear !== 1'b1) begin errors++; $display("FAIL basic_swap front=%b count=%0d clear=%b want 1 1 1", front_buffer, frame_count, clear); end
        end
        default: ;
      endcase
      if (k == 1 || k == 201) vsync = 1'b0;
      if (k == 49) render_done = 1'b1;
      if (k == 50) render_done = 1'b0;
      if (k == 200) vsync = 1'b1;
    end
  endtask

  task automatic test_overrun();
    repeat (10) tick();                    // into WAIT_RENDER
    vsync_edge();
    checks++; if (drop_count !== 16'd1 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_first drop=%0d ovr=%b want 1 1", drop_count, overrun); end
    repeat (4) tick();
    vsync_edge(); repeat (4) tick();
    vsync_edge();
    checks++; if (drop_count !== 16'd3 || front_buffer !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL overrun_three drop=%0d front=%b count=%0d want 3 1 1", drop_count, front_buffer, frame_count); end
    done_pulse();
    repeat (3) tick();
    vsync_edge();
    checks++; if (front_buffer !== 1'b0 || frame_count !== 16'd2 || drop_count !== 16'd3) begin errors++; $display("FAIL overrun_swap front=%b count=%0d drop=%0d want 0 2 3", front_buffer, frame_count, drop_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    flags_clr = 1'b1; tick(); flags_clr = 1'b0;
    checks++; if (overrun !== 1'b0 || drop_count !== 16'd3) begin errors++; $display("FAIL overrun_clr ovr=%b drop=%0d want 0 3", overrun, drop_count); end
  endtask

  task automatic test_same_cycle();
    repeat (10) tick();                    // into WAIT_RENDER
    vsync = 1'b1; tick(); vsync = 1'b0;
    tick(); tick();                        // vs_rise is high in the next cycle
    render_done = 1'b1;
    checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL same_pre front got %b want 0", front_buffer); end
    tick();
    render_done = 1'b0;
    checks++; if (front_buffer !== 1'b1 || frame_count !== 16'd3 || drop_count !== 16'd3 || overrun !== 1'b0) begin errors++; $display("FAIL same_swap front=%b count=%0d drop=%0d ovr=%b want 1 3 3 0", front_buffer, frame_count, drop_count, overrun); end
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL same_clear got %b want 1", clear); end
    tick();
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL same_clear_pulse got %b want 0", clear); end
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (render_start) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_start render_start not seen within 10 cycles"); end
    repeat (99) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0 at 99", timeout); end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_at100 got %b want 1", timeout); end
    repeat (3) tick();
    vsync_edge();
    checks++; if (front_buffer !== 1'b1 || frame_count !== 16'd3 || clear !== 1'b1) begin errors++; $display("FAIL timeout_noswap front=%b count=%0d clear=%b want 1 3 1", front_buffer, frame_count, clear); end
  endtask

  task automatic test_ready_wait();
    bit early = 1'b0;
    buffers_ready = 1'b0;                  // clear is high this cycle
    repeat (40) begin
      tick();
      if (render_start) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL ready_early render_start got 1 want 0"); end
    buffers_ready = 1'b1;
    tick();
    checks++; if (render_start !== 1'b1) begin errors++; $display("FAIL ready_start got %b want 1", render_start); end
    flags_clr = 1'b1; tick(); flags_clr = 1'b0;
    checks++; if (timeout !== 1'b0 || render_start !== 1'b0) begin errors++; $display("FAIL ready_flagclr tmo=%b start=%b want 0 0", timeout, render_start); end
  endtask

  task automatic test_enable_off();
    repeat (3) tick();
    enable = 1'b0;
    repeat (5) tick();
    done_pulse();
    repeat (3) tick();
    vsync_edge();
    checks++; if (front_buffer !== 1'b0 || frame_count !== 16'd4 || busy !== 1'b0 || clear !== 1'b0) begin errors++; $display("FAIL enoff_swap front=%b count=%0d busy=%b clear=%b want 0 4 0 0", front_buffer, frame_count, busy, clear); end
    repeat (4) tick();
    vsync_edge();
    checks++; if (front_buffer !== 1'b0 || frame_count !== 16'd4 || busy !== 1'b0 || clear !== 1'b0) begin errors++; $display("FAIL enoff_ignore front=%b count=%0d busy=%b clear=%b want 0 4 0 0", front_buffer, frame_count, busy, clear); end
  endtask

  task automatic test_reset_mid();
    logic [37:0] outs;
    enable = 1'b1;
    vsync_edge();
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL rmid_clear got %b want 1", clear); end
    repeat (6) tick();
    done_pulse();                          // render_done never reaches a swap
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", busy); end
    #2;
    rstn = 1'b0;
    #1;
    outs = {clear, render_start, front_buffer, busy, overrun, timeout, frame_count, drop_count};
    checks++; if (outs !== 38'd0) begin errors++; $display("FAIL rmid_outputs got %h want 0", outs); end
    #3;
    rstn = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || frame_count !== 16'd0 || front_buffer !== 1'b0) begin errors++; $display("FAIL rmid_after busy=%b count=%0d front=%b want 0 0 0", busy, frame_count, front_buffer); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_same_cycle();
    test_timeout();
    test_ready_wait();
    test_enable_off();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
